// File: rtl/rope_speed_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rope_speed_gen
//  Description : Fills ROPES speed channels from one shared Galois LFSR, one
//                draw per cycle. Each channel has its own [min,max] window.
//                Out-of-window draws are retried, then fall back to the window
//                midpoint. All speeds are committed together with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rope_speed_gen #(
    parameter int ROPES      = 6,
    parameter int LEFT_ROPES = 3,
    parameter int SIZE_BITS  = 7,
    parameter int BASE_MIN   = 45,
    parameter int BASE_MAX   = 70,
    parameter int STEP       = 7,
    parameter int MAX_TRIES  = 8,
    parameter int LFSR_BITS  = 16,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'hACE1,
    parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 trigger,
    input  logic [ROPES-1:0]                     ch_mask,
    input  logic                                 seed_load,
    input  logic [LFSR_BITS-1:0]                 seed_in,
    output logic                                 busy,
    output logic                                 done,
    output logic [ROPES-1:0][SIZE_BITS-1:0]      X_SPEED
);

    typedef logic [ROPES-1:0][SIZE_BITS-1:0] speed_vec_t;

    // Left channels widen upwards with index, right channels narrow from below.
    function automatic int win_min(input int i);
        return (i < LEFT_ROPES) ? BASE_MIN : BASE_MIN + STEP * (i - LEFT_ROPES);
    endfunction

    function automatic int win_max(input int i);
        return (i < LEFT_ROPES) ? BASE_MAX + STEP * i : BASE_MAX;
    endfunction

    function automatic int max_span();
        int m;
        m = 0;
        for (int i = 0; i < ROPES; i++) begin
            if (win_max(i) - win_min(i) > m) m = win_max(i) - win_min(i);
        end
        return m;
    endfunction

    function automatic speed_vec_t min_vec();
        speed_vec_t v;
        v = '0;
        for (int i = 0; i < ROPES; i++) v[i] = SIZE_BITS'(win_min(i));
        return v;
    endfunction

    function automatic speed_vec_t span_vec();
        speed_vec_t v;
        v = '0;
        for (int i = 0; i < ROPES; i++) v[i] = SIZE_BITS'(win_max(i) - win_min(i));
        return v;
    endfunction

    function automatic speed_vec_t mid_vec();
        speed_vec_t v;
        v = '0;
        for (int i = 0; i < ROPES; i++)
            v[i] = SIZE_BITS'(win_min(i) + (win_max(i) - win_min(i)) / 2);
        return v;
    endfunction

    localparam int         c_RB_RAW   = $clog2(max_span() + 1);
    localparam int         c_RB       = (c_RB_RAW < 1) ? 1 : c_RB_RAW;
    localparam int         c_CHW      = (ROPES > 1) ? $clog2(ROPES) : 1;
    localparam int         c_TW       = $clog2(MAX_TRIES + 1);
    localparam speed_vec_t c_MIN_VEC  = min_vec();
    localparam speed_vec_t c_SPAN_VEC = span_vec();
    localparam speed_vec_t c_MID_VEC  = mid_vec();
    // An all-zero state would lock the LFSR, so the reset seed is nudged to 1.
    localparam logic [LFSR_BITS-1:0] c_SEED = (SEED == '0) ? LFSR_BITS'(1) : SEED;

    // Reject parameter sets whose windows cannot be represented.
    for (genvar gi = 0; gi < ROPES; gi++) begin : g_check
        if (win_max(gi) >= (1 << SIZE_BITS)) begin : g_max_err
            $error("rope_speed_gen: window max does not fit in SIZE_BITS");
        end
        if (win_min(gi) > win_max(gi)) begin : g_order_err
            $error("rope_speed_gen: window min exceeds max");
        end
    end
    if (MAX_TRIES < 1 || c_RB > LFSR_BITS) begin : g_cfg_err
        $error("rope_speed_gen: MAX_TRIES must be >=1 and draw width must fit the LFSR");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GEN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                 r_state, w_state_n;
    logic [LFSR_BITS-1:0]   r_lfsr;
    logic                   r_trig_q;
    logic                   r_pending, w_pending_n;
    logic [ROPES-1:0]       r_mask, w_mask_n;
    logic [c_CHW-1:0]       r_ch, w_ch_n;
    logic [c_TW-1:0]        r_tries, w_tries_n;
    speed_vec_t             r_shadow, w_shadow_n;
    logic                   w_advance;
    logic                   w_commit;
    logic                   w_rise;
    logic [SIZE_BITS-1:0]   w_draw;
    logic [LFSR_BITS-1:0]   w_lfsr_adv;

    assign w_rise     = trigger & ~r_trig_q;
    assign w_draw     = SIZE_BITS'(r_lfsr[c_RB-1:0]);
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

    // Free-running LFSR; a seed load wins over the advance, even mid-run.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)        r_lfsr <= c_SEED;
        else if (seed_load) r_lfsr <= (seed_in == '0) ? LFSR_BITS'(1) : seed_in;
        else                r_lfsr <= w_lfsr_adv;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_state_n;
    end

    // Next-state, per-channel draw evaluation and handshake outputs.
    always_comb begin
        w_state_n   = r_state;
        w_ch_n      = r_ch;
        w_tries_n   = r_tries;
        w_mask_n    = r_mask;
        w_pending_n = r_pending;
        w_shadow_n  = r_shadow;
        w_advance   = 1'b0;
        w_commit    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise || r_pending) begin
                    w_mask_n    = ch_mask;
                    w_ch_n      = '0;
                    w_tries_n   = '0;
                    w_pending_n = 1'b0;
                    w_state_n   = S_GEN;
                end
            end
            S_GEN: begin
                busy = 1'b1;
                if (w_rise) w_pending_n = 1'b1;
                if (!r_mask[r_ch]) begin
                    w_shadow_n[r_ch] = X_SPEED[r_ch];
                    w_advance        = 1'b1;
                end else if (w_draw <= c_SPAN_VEC[r_ch]) begin
                    w_shadow_n[r_ch] = c_MIN_VEC[r_ch] + w_draw;
                    w_advance        = 1'b1;
                end else if (r_tries == c_TW'(MAX_TRIES - 1)) begin
                    w_shadow_n[r_ch] = c_MID_VEC[r_ch];
                    w_advance        = 1'b1;
                end else begin
                    w_tries_n = r_tries + c_TW'(1);
                end
                if (w_advance) begin
                    w_tries_n = '0;
                    if (r_ch == c_CHW'(ROPES - 1)) w_state_n = S_COMMIT;
                    else                           w_ch_n    = r_ch + c_CHW'(1);
                end
            end
            S_COMMIT: begin
                busy      = 1'b1;
                done      = 1'b1;
                w_commit  = 1'b1;
                if (w_rise) w_pending_n = 1'b1;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Run bookkeeping, shadow speeds and the atomic commit of X_SPEED.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_trig_q  <= 1'b0;
            r_pending <= 1'b0;
            r_mask    <= '0;
            r_ch      <= '0;
            r_tries   <= '0;
            r_shadow  <= c_MIN_VEC;
            X_SPEED   <= c_MIN_VEC;
        end else begin
            r_trig_q  <= trigger;
            r_pending <= w_pending_n;
            r_mask    <= w_mask_n;
            r_ch      <= w_ch_n;
            r_tries   <= w_tries_n;
            r_shadow  <= w_shadow_n;
            if (w_commit) X_SPEED <= r_shadow;
        end
    end

endmodule
`default_nettype wire
